// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - round-robin arbiter and sequencer for the shared RTC address/data bus
// Grants one of three requesters and runs ADDR, TURN, DATA, RECOV phases on its behalf.
module rtc_bus_arbiter #(
  parameter int PHASE_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  wr,
  input  logic [23:0] addr_in,
  input  logic [23:0] wdata_in,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic        A_D,
  output logic        W_R,
  output logic        R_D,
  output logic        cs,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [7:0]  rdata,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_TURN  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_RECOV = 3'd4;

  localparam logic [7:0] CNT_LOAD = 8'(PHASE_CYC - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [1:0] last_grant;
  logic       lat_wr;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [1:0] win;
  logic [1:0] cand;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int step);
    int s;
    s = (int'(base) + step) % 3;
    return 2'(s);
  endfunction

  // Scan from the farthest candidate back to the nearest so the nearest set request wins.
  always_comb begin
    win  = last_grant;
    cand = last_grant;
    for (int i = 3; i >= 1; i--) begin
      cand = rr_idx(last_grant, i);
      if (req[cand]) win = cand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      last_grant <= 2'd2;
      lat_wr     <= 1'b0;
      lat_addr   <= 8'h00;
      lat_wdata  <= 8'h00;
      bus_out    <= 8'h00;
      bus_oe     <= 1'b0;
      A_D        <= 1'b0;
      W_R        <= 1'b0;
      R_D        <= 1'b0;
      cs         <= 1'b0;
      grant      <= 3'b000;
      done       <= 3'b000;
      rdata      <= 8'h00;
      busy       <= 1'b0;
    end else begin
      done <= 3'b000;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state      <= S_ADDR;
            cnt        <= CNT_LOAD;
            last_grant <= win;
            grant      <= 3'b001 << win;
            lat_wr     <= wr[win];
            lat_addr   <= addr_in[{win, 3'b000} +: 8];
            lat_wdata  <= wdata_in[{win, 3'b000} +: 8];
            bus_out    <= addr_in[{win, 3'b000} +: 8];
            bus_oe     <= 1'b1;
            A_D        <= 1'b1;
            cs         <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_ADDR: begin
          if (cnt == 8'd0) begin
            state  <= S_TURN;
            A_D    <= 1'b0;
            bus_oe <= lat_wr;
            // A read leaves the address on bus_out; only bus_oe drops.
            if (lat_wr) bus_out <= lat_wdata;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_TURN: begin
          state <= S_DATA;
          cnt   <= CNT_LOAD;
          W_R   <= lat_wr;
          R_D   <= ~lat_wr;
        end
        S_DATA: begin
          if (cnt == 8'd0) begin
            state  <= S_RECOV;
            cnt    <= CNT_LOAD;
            W_R    <= 1'b0;
            R_D    <= 1'b0;
            cs     <= 1'b0;
            bus_oe <= 1'b0;
            done   <= grant;
            if (!lat_wr) rdata <= bus_in;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_RECOV: begin
          if (cnt == 8'd0) begin
            state <= S_IDLE;
            grant <= 3'b000;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - bench for rtc_bus_arbiter at PHASE_CYC 4 and 1
// A transaction-level model predicts every output from the cycle offset within the current transfer.
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [23:0] addr_in;
  logic [23:0] wdata_in;
  logic [7:0]  bus_in;

  logic [7:0]  bo  [2];
  logic        oe  [2];
  logic        ad  [2];
  logic        wrs [2];
  logic        rds [2];
  logic        css [2];
  logic        bsy [2];
  logic [2:0]  gr  [2];
  logic [2:0]  dn  [2];
  logic [7:0]  rd  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.PHASE_CYC(4)) u_p4 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr_in(addr_in), .wdata_in(wdata_in),
    .bus_in(bus_in), .bus_out(bo[0]), .bus_oe(oe[0]), .A_D(ad[0]), .W_R(wrs[0]), .R_D(rds[0]),
    .cs(css[0]), .grant(gr[0]), .done(dn[0]), .rdata(rd[0]), .busy(bsy[0])
  );

  rtc_bus_arbiter #(.PHASE_CYC(1)) u_p1 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr_in(addr_in), .wdata_in(wdata_in),
    .bus_in(bus_in), .bus_out(bo[1]), .bus_oe(oe[1]), .A_D(ad[1]), .W_R(wrs[1]), .R_D(rds[1]),
    .cs(css[1]), .grant(gr[1]), .done(dn[1]), .rdata(rd[1]), .busy(bsy[1])
  );

  function automatic int pcyc(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  // Model state: active transfer, offset k since the sampling edge, latched request data.
  bit         mact  [2];
  int         mk    [2];
  int         mown  [2];
  int         mlg   [2];
  bit         mwr   [2];
  logic [7:0] maddr [2];
  logic [7:0] mwd   [2];
  logic [7:0] mrd   [2];
  logic [7:0] mlast [2];

  always @(posedge clk or posedge reset) begin
    for (int g = 0; g < 2; g++) begin
      int p;
      int w;
      p = pcyc(g);
      w = -1;
      if (reset) begin
        mact[g] = 1'b0; mk[g] = 0; mown[g] = 0; mlg[g] = 2; mwr[g] = 1'b0;
        maddr[g] = 8'h00; mwd[g] = 8'h00; mrd[g] = 8'h00; mlast[g] = 8'h00;
      end else begin
        if (mact[g]) begin
          mk[g]++;
          if (mk[g] == 2 * p + 2 && !mwr[g]) mrd[g] = bus_in;
          if (mk[g] == 3 * p + 2) mact[g] = 1'b0;
        end else if (req != 3'b000) begin
          for (int i = 1; i <= 3; i++) begin
            int c;
            c = (mlg[g] + i) % 3;
            if (w < 0 && req[c]) w = c;
          end
          mown[g] = w; mlg[g] = w; mwr[g] = wr[w];
          maddr[g] = addr_in[8 * w +: 8];
          mwd[g] = wdata_in[8 * w +: 8];
          mact[g] = 1'b1; mk[g] = 1;
        end
        if (mact[g] && mk[g] >= 1 && mk[g] <= p) mlast[g] = maddr[g];
        else if (mact[g] && mwr[g] && mk[g] >= p + 1 && mk[g] <= 2 * p + 1) mlast[g] = mwd[g];
      end
    end
  end

  task automatic chk(input string nm, input int g, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, g, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      int p;
      int k;
      logic ea, ecs, edat, eoe;
      logic [2:0] eg, ed;
      p = pcyc(g);
      k = mact[g] ? mk[g] : 0;
      ea   = (k >= 1 && k <= p);
      ecs  = (k >= 1 && k <= 2 * p + 1);
      edat = (k >= p + 2 && k <= 2 * p + 1);
      eoe  = ea || (mwr[g] && k >= p + 1 && k <= 2 * p + 1);
      eg   = mact[g] ? 3'(1 << mown[g]) : 3'b000;
      ed   = (k == 2 * p + 2) ? eg : 3'b000;
      chk("A_D", g, 8'(ad[g]), 8'(ea));
      chk("cs", g, 8'(css[g]), 8'(ecs));
      chk("W_R", g, 8'(wrs[g]), 8'(edat && mwr[g]));
      chk("R_D", g, 8'(rds[g]), 8'(edat && !mwr[g]));
      chk("bus_oe", g, 8'(oe[g]), 8'(eoe));
      chk("bus_out", g, bo[g], mlast[g]);
      chk("grant", g, 8'(gr[g]), 8'(eg));
      chk("done", g, 8'(dn[g]), 8'(ed));
      chk("rdata", g, rd[g], mrd[g]);
      chk("busy", g, 8'(bsy[g]), 8'(mact[g]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic check_reset_lit(input int g);
    chk("rst_bus_out", g, bo[g], 8'h00);
    chk("rst_oe", g, 8'(oe[g]), 8'd0);
    chk("rst_strobes", g, 8'({ad[g], wrs[g], rds[g], css[g]}), 8'd0);
    chk("rst_grant", g, 8'(gr[g]), 8'd0);
    chk("rst_done", g, 8'(dn[g]), 8'd0);
    chk("rst_rdata", g, rd[g], 8'h00);
    chk("rst_busy", g, 8'(bsy[g]), 8'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bsy[0] || bsy[1]) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle", 0, 8'(bsy[0] || bsy[1]), 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [2:0] fair_exp [5];
    int ad_n, wr_n, dn_n;
    fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100};
    reset = 1'b1; req = 3'b000; wr = 3'b000; addr_in = 24'h0; wdata_in = 24'h0; bus_in = 8'h00;
    tick(); tick();
    check_reset_lit(0);
    check_reset_lit(1);
    reset = 1'b0;
    tick();

    // Write from requester 1 at P=4.
    req = 3'b010; wr = 3'b010; addr_in = 24'h000400; wdata_in = 24'h003500;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) req = 3'b000;
      if (c >= 1 && c <= 4) begin chk("wr_ad", 0, 8'(ad[0]), 8'd1); chk("wr_addr", 0, bo[0], 8'h04); end
      if (c == 5) begin chk("wr_turn_ad", 0, 8'(ad[0]), 8'd0); chk("wr_turn_oe", 0, 8'(oe[0]), 8'd1); end
      if (c >= 6 && c <= 9) begin chk("wr_wr", 0, 8'(wrs[0]), 8'd1); chk("wr_data", 0, bo[0], 8'h35); end
      if (c == 10) chk("wr_done", 0, 8'(dn[0]), 8'b010);
      if (c == 14) begin chk("wr_end_grant", 0, 8'(gr[0]), 8'd0); chk("wr_end_busy", 0, 8'(bsy[0]), 8'd0); end
    end

    // Read from requester 0 at P=4.
    req = 3'b001; wr = 3'b000; addr_in = 24'h000000; bus_in = 8'h59;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) req = 3'b000;
      if (c >= 5 && c <= 9) chk("rd_oe", 0, 8'(oe[0]), 8'd0);
      if (c >= 6 && c <= 9) chk("rd_rd", 0, 8'(rds[0]), 8'd1);
      if (c == 10) begin chk("rd_rdata", 0, rd[0], 8'h59); chk("rd_done", 0, 8'(dn[0]), 8'b001); end
    end

    // Fairness from reset, then req=101 after owner 2.
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    req = 3'b111; wr = 3'b101; addr_in = 24'h123456; wdata_in = 24'hABCDEF;
    for (int c = 1; c <= 57; c++) begin
      tick();
      if (c == 30) req = 3'b101;
      for (int i = 0; i < 5; i++)
        if (c == 1 + 14 * i) chk("fair_grant", 0, 8'(gr[0]), 8'(fair_exp[i]));
    end
    req = 3'b000;
    wait_idle();

    // Latched values survive input changes and a dropped request.
    req = 3'b100; wr = 3'b100; addr_in = 24'hA50000; wdata_in = 24'h3C0000;
    dn_n = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 7) begin req = 3'b000; wr = 3'b000; addr_in = 24'h5A5A5A; wdata_in = 24'hC3C3C3; end
      if (c == 8) chk("stab_data", 0, bo[0], 8'h3C);
      if (dn[0] != 3'b000) dn_n++;
    end
    chk("stab_done_count", 0, 8'(dn_n), 8'd1);
    wait_idle();

    // Reset in the middle of a write's DATA phase.
    req = 3'b010; wr = 3'b010; addr_in = 24'h001100; wdata_in = 24'h002200;
    for (int c = 1; c <= 7; c++) tick();
    reset = 1'b1;
    #1;
    check_reset_lit(0);
    tick(); tick(); tick();
    reset = 1'b0; req = 3'b111;
    tick();
    chk("post_reset_grant", 0, 8'(gr[0]), 8'b001);
    req = 3'b000;
    wait_idle();

    // Back-to-back writes from requester 2 at P=1.
    req = 3'b100; wr = 3'b100; addr_in = 24'h770000; wdata_in = 24'h880000;
    ad_n = 0; wr_n = 0; dn_n = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 14) req = 3'b000;
      ad_n += int'(ad[1]);
      wr_n += int'(wrs[1]);
      if (dn[1] == 3'b100) dn_n++;
      if (c == 1 || c == 6 || c == 11) chk("p1_grant", 1, 8'(gr[1]), 8'b100);
      if (c == 5 || c == 10 || c == 15) chk("p1_idle", 1, 8'(bsy[1]), 8'd0);
    end
    chk("p1_ad_cycles", 1, 8'(ad_n), 8'd3);
    chk("p1_wr_cycles", 1, 8'(wr_n), 8'd3);
    chk("p1_done_count", 1, 8'(dn_n), 8'd3);
    wait_idle();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      req = 3'($urandom);
      wr = 3'($urandom);
      addr_in = 24'($urandom);
      wdata_in = 24'($urandom);
      bus_in = 8'($urandom);
      tick();
    end
    reset = 1'b0; req = 3'b000;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Round-robin arbiter and bus sequencer for the shared RTC multiplexed address/data bus. Three requesters share the one RTC port: periodic time read-back, clock/date set machine and chronometer set machine. The block grants one requester at a time and runs a complete address-phase/data-phase cycle on its behalf. It drives the bus, A/D, W/R, R/D and chip select, captures read data, and returns a one-cycle done pulse to the winner.

## Interface
Parameters:
- PHASE_CYC, 4: cycles per ADDR, DATA and RECOV phase; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  3  request per requester; index 0 = read-back, 1 = clock set, 2 = chrono set
- wr  in  3  per-requester transfer type; 1 = write, 0 = read
- addr_in  in  24  per-requester RTC register address; requester n on bits [8n+7:8n]
- wdata_in  in  24  per-requester write data, same packing as addr_in
- bus_in  in  8  RTC bus read-back
- bus_out  out  8  value driven onto the RTC bus
- bus_oe  out  1  bus output enable
- A_D  out  1  address strobe; 1 during ADDR
- W_R  out  1  write strobe; 1 during DATA of a write
- R_D  out  1  read strobe; 1 during DATA of a read
- cs  out  1  RTC chip select; 1 from ADDR through DATA
- grant  out  3  one-hot owner; 0 when idle
- done  out  3  one-cycle completion pulse to the owner
- rdata  out  8  last captured read data
- busy  out  1  1 in every state except IDLE

## Operation
- FSM states: IDLE, ADDR, TURN, DATA, RECOV. Phase counter is 8 bits wide.
- IDLE: if req is nonzero, pick the winner, latch its wr, addr and wdata, set grant, and go to ADDR.
- Arbitration is round-robin. The search starts at last_grant+1 (mod 3); the first set req bit wins.
  - last_grant resets to 2, so requester 0 wins first.
  - last_grant updates when ADDR is entered.
- ADDR (PHASE_CYC cycles): A_D=1, cs=1, bus_oe=1, bus_out=latched addr.
- TURN (1 cycle): A_D=0, strobes 0, cs=1.
  - Write: bus_out=wdata, bus_oe=1.
  - Read: bus_oe=0.
- DATA (PHASE_CYC cycles), cs=1:
  - Write: W_R=1, bus_out=wdata, bus_oe=1.
  - Read: R_D=1, bus_oe=0; rdata <= bus_in on the last DATA cycle.
- RECOV (PHASE_CYC cycles): cs, strobes and bus_oe all 0; bus_out holds its last value.
  - done[owner]=1 on the first RECOV cycle only.
  - grant stays set through the end of RECOV, then clears on return to IDLE.
- Latched wr, addr and wdata are used for the whole transaction. Input changes after the grant have no effect.
- Dropping req mid-transaction does not abort; the cycle completes and done still pulses.
- req is ignored outside IDLE. A req still high in IDLE starts a new transaction and is re-arbitrated fairly.
- rdata holds its value until the next read completes; writes do not change it.

## Timing
- Reset values: bus_out=0x00, bus_oe=0, A_D=0, W_R=0, R_D=0, cs=0, grant=000, done=000, rdata=0x00, busy=0, FSM=IDLE, last_grant=2.
- Take cycle 0 as the IDLE cycle in which req is sampled (P=PHASE_CYC):
  - ADDR: cycles 1..P.
  - TURN: cycle P+1.
  - DATA: cycles P+2..2P+1.
  - RECOV: cycles 2P+2..3P+1; done on 2P+2.
  - IDLE: cycle 3P+2, the earliest next grant.
- Minimum transaction time is 3P+2 cycles from request to next arbitration.
- All outputs are registered; none depends combinationally on req or bus_in.
- Simultaneous requests are resolved only in IDLE. Under continuous requests from all three, grants run strictly 0, 1, 2, 0, …
- Asserting reset in any state clears all outputs immediately and returns to IDLE; no done is issued for the aborted transaction.
- P=1 is legal: each phase lasts 1 cycle, for a total of 5 cycles.

## Test plan
- Write, P=4: req=010, wr[1]=1, addr 0x04, data 0x35.
  - A_D=1 with bus 0x04 in cycles 1–4.
  - Cycle 5 is TURN.
  - W_R=1 with bus 0x35 in cycles 6–9.
  - done=010 at cycle 10; grant=000 and busy=0 at cycle 14.
- Read, P=4: req=001, addr 0x00, bus_in=0x59 held.
  - R_D=1 in cycles 6–9, bus_oe=0 in cycles 5–9.
  - rdata=0x59 and done=001 at cycle 10.
- Fairness: req=111 held after reset.
  - Grant order is 001, 010, 100, 001.
  - Then with req=101, the next grant is 001 (previous owner was 2), then 100.
- Input stability: change addr_in and wdata_in and drop req during DATA.
  - Bus keeps the originally latched values.
  - done still pulses exactly once.
- Reset mid-DATA of a write:
  - All outputs return to reset values within the same cycle.
  - No done pulse.
  - The next request after release restarts from requester 0 priority.
- Boundary P=1: back-to-back writes from requester 2.
  - Each transaction takes 5 cycles.
  - One done pulse per transaction.
  - A_D and W_R each high for exactly 1 cycle.
